falafel_req_arbiter: RTL

- Shares one allocator core between NUM_REQ requesters (CPU ports or accelerators) using round-robin arbitration.
- Accepts one request at a time, forwards it to the core, and routes the core's response back to the granted requester.
- Filters trivial and illegal requests locally, so they never occupy the core.
- Sits between the requester fabric and the allocator core's request/response handshake.

---
 rtl/falafel_req_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/falafel_req_arbiter.sv
// Round-robin arbiter sharing one allocator core between NUM_REQ requesters.
// Optional FALAFEL_ARB_ALIGN_EN: align REQ_ALLOC_MEM sizes before forwarding to the core.
module falafel_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_opcode_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic                      core_req_valid_o,
  input  logic                      core_req_ready_i,
  output logic [DATA_W-1:0]         core_req_opcode_o,
  output logic [DATA_W-1:0]         core_req_data_o,
  input  logic                      core_resp_valid_i,
  output logic                      core_resp_ready_o,
  input  logic [DATA_W-1:0]         core_resp_data_i,
  output logic                      busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [DATA_W-1:0] ReqFreeMem = DATA_W'(2);
  localparam logic [DATA_W-1:0] NullPtr    = '0;
  localparam logic [DATA_W-1:0] ErrNomem   = '1;

`ifdef FALAFEL_ARB_ALIGN_EN
  localparam logic [DATA_W-1:0] ReqAllocMem    = DATA_W'(1);
  localparam logic [DATA_W-1:0] MinPayloadSize = DATA_W'(32);
  localparam logic [DATA_W-1:0] BlockAlignment = DATA_W'(8);

  function automatic logic [DATA_W-1:0] align_size(input logic [DATA_W-1:0] size,
                                                   input logic [DATA_W-1:0] align);
    logic [DATA_W-1:0] rounded;
    rounded = (size + align - DATA_W'(1)) & ~(align - DATA_W'(1));
    if (rounded < MinPayloadSize) begin
      rounded = MinPayloadSize;
    end
    return rounded;
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   grant_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] resp_q;

  logic [IdxW-1:0]   grant_idx;
  logic              grant_found;
  logic [DATA_W-1:0] sel_opcode;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] fwd_data;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] cand;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand = IdxW'(idx);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_opcode = req_opcode_i[grant_idx*DATA_W +: DATA_W];
  assign sel_data   = req_data_i[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    fwd_data = sel_data;
`ifdef FALAFEL_ARB_ALIGN_EN
    if (sel_opcode == ReqAllocMem) begin
      fwd_data = align_size(sel_data, BlockAlignment);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      opcode_q <= '0;
      data_q   <= '0;
      resp_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            grant_q  <= grant_idx;
            opcode_q <= sel_opcode;
            data_q   <= fwd_data;
            // Illegal opcodes and NULL frees are answered locally without touching the core.
            if (sel_opcode > ReqFreeMem) begin
              resp_q  <= ErrNomem;
              state_q <= StResp;
            end else if (sel_opcode == ReqFreeMem && sel_data == NullPtr) begin
              resp_q  <= '0;
              state_q <= StResp;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (core_req_ready_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (core_resp_valid_i) begin
            resp_q  <= core_resp_data_i;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ready_i[grant_q]) begin
            rr_ptr_q <= (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (state_q == StIdle && grant_found) begin
      req_ready_o = NUM_REQ'(1) << grant_idx;
    end
    if (state_q == StResp) begin
      resp_valid_o = NUM_REQ'(1) << grant_q;
    end
  end

  assign resp_data_o       = resp_q;
  assign core_req_valid_o  = (state_q == StIssue);
  assign core_req_opcode_o = opcode_q;
  assign core_req_data_o   = data_q;
  assign core_resp_ready_o = (state_q == StWait);
  assign busy_o            = (state_q != StIdle);

  // A core response is only legal while the arbiter is waiting for one.
  core_resp_in_wait_a: assert property (@(posedge clk_i) disable iff (rst_i)
    core_resp_valid_i |-> (state_q == StWait));

endmodule
